// File: rtl/useq_ctrl_if.sv
// Signal bundle between the microprogram sequencer and its surroundings
// (microcode ROM, instruction register, ALU flags, memory port, register bank).
//
// Memory handshake: the sequencer raises mem_req on the edge that registers a
// memory microinstruction and holds it high until it samples mem_ack=1 on a
// rising edge. The responder pulses mem_ack for exactly one cycle. mem_req
// drops on that same edge. mem_ack seen while mem_req is low has no effect.
interface useq_ctrl_if #(
  parameter int UA_W = 8
);
  logic            start;
  logic [UA_W-1:0] uaddr;
  logic [35:0]     uinstr;
  logic [UA_W-1:0] opcode;
  logic            flag_z;
  logic            flag_n;
  logic            flag_c;
  logic            mem_req;
  logic            mem_ack;
  logic [1:0]      MC;
  logic [5:0]      WRC;
  logic [4:0]      busA;
  logic [5:0]      busB;
  logic [3:0]      alu_op;
  logic            halted;
  logic            err;
  logic [1:0]      dbg_state;

  // Sequencer side
  modport master (
    input  start, uinstr, opcode, flag_z, flag_n, flag_c, mem_ack,
    output uaddr, mem_req, MC, WRC, busA, busB, alu_op, halted, err, dbg_state
  );

  // Environment side (ROM, IR, ALU, memory, register bank)
  modport slave (
    output start, uinstr, opcode, flag_z, flag_n, flag_c, mem_ack,
    input  uaddr, mem_req, MC, WRC, busA, busB, alu_op, halted, err, dbg_state
  );
endinterface

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: one microinstruction per cycle from an asynchronous
// ROM, registered control fields, flag branches, opcode dispatch, a small
// call/return stack and a stall on memory microinstructions.
// dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 MEMWAIT, 3 HALT).
module useq_ctrl #(
  parameter int         UA_W    = 8,
  parameter int         STK_D   = 4,
  parameter logic [5:0] NOP_WRC = 6'h3F
) (
  input logic         clk,
  input logic         rst_n,
  useq_ctrl_if.master bus
);

  localparam int SP_W = $clog2(STK_D + 1);
  localparam int IX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

  localparam logic [2:0] NXT_INC     = 3'd0;
  localparam logic [2:0] NXT_JMP     = 3'd1;
  localparam logic [2:0] NXT_CJMP    = 3'd2;
  localparam logic [2:0] NXT_DISP    = 3'd3;
  localparam logic [2:0] NXT_CALL    = 3'd4;
  localparam logic [2:0] NXT_RET     = 3'd5;
  localparam logic [2:0] NXT_HALT    = 3'd6;
  localparam logic [2:0] NXT_RESTART = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [UA_W-1:0] upc_q, upc_d;
  logic [1:0]      mc_q, mc_d;
  logic [5:0]      wrc_q, wrc_d;
  logic [4:0]      a_q, a_d;
  logic [5:0]      b_q, b_d;
  logic [3:0]      alu_q, alu_d;
  logic            mem_req_q, mem_req_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  // A memory microinstruction that also halts: halt once the handshake ends.
  logic            halt_pend_q, halt_pend_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [UA_W-1:0] stk_q [STK_D];
  logic [UA_W-1:0] stk_d [STK_D];

  // Microinstruction fields
  logic [1:0]      f_mc;
  logic [5:0]      f_wrc;
  logic [4:0]      f_a;
  logic [5:0]      f_b;
  logic [3:0]      f_alu;
  logic [2:0]      f_nxt;
  logic [1:0]      f_cond;
  logic [UA_W-1:0] f_target;

  logic [UA_W-1:0] upc_inc;
  logic            cond_true;
  logic            stk_full;
  logic            stk_empty;
  logic            is_mem;
  logic            fault;
  logic [IX_W-1:0] push_ix;
  logic [IX_W-1:0] pop_ix;

  assign f_mc     = bus.uinstr[35:34];
  assign f_wrc    = bus.uinstr[33:28];
  assign f_a      = bus.uinstr[27:23];
  assign f_b      = bus.uinstr[22:17];
  assign f_alu    = bus.uinstr[16:13];
  assign f_nxt    = bus.uinstr[12:10];
  assign f_cond   = bus.uinstr[9:8];
  assign f_target = UA_W'(bus.uinstr[7:0]);

  assign upc_inc   = upc_q + UA_W'(1);
  assign stk_full  = (sp_q == SP_W'(STK_D));
  assign stk_empty = (sp_q == '0);
  assign push_ix   = IX_W'(sp_q);
  assign pop_ix    = IX_W'(sp_q - SP_W'(1));
  assign is_mem    = (f_mc == 2'b01) || (f_mc == 2'b10);
  assign fault     = (f_mc == 2'b11) ||
                     ((f_nxt == NXT_CALL) && stk_full) ||
                     ((f_nxt == NXT_RET) && stk_empty);

  // Branch condition select on the flags present at the executing edge
  always_comb begin
    cond_true = 1'b1;
    case (f_cond)
      2'b00:   cond_true = bus.flag_z;
      2'b01:   cond_true = bus.flag_n;
      2'b10:   cond_true = bus.flag_c;
      default: cond_true = 1'b1;
    endcase
  end

  // Next-state, next-upc, stack and control-field logic
  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    mc_d        = mc_q;
    wrc_d       = wrc_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    mem_req_d   = mem_req_q;
    halted_d    = halted_q;
    err_d       = err_q;
    halt_pend_d = halt_pend_q;
    sp_d        = sp_q;
    stk_d       = stk_q;

    case (state_q)
      S_IDLE: begin
        mc_d  = 2'b00;
        wrc_d = NOP_WRC;
        a_d   = '0;
        b_d   = '0;
        alu_d = '0;
        if (bus.start) begin
          state_d = S_RUN;
          upc_d   = '0;
        end
      end

      S_RUN: begin
        if (fault) begin
          err_d     = 1'b1;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_HALT;
          mc_d      = 2'b00;
          wrc_d     = NOP_WRC;
          a_d       = '0;
          b_d       = '0;
          alu_d     = '0;
        end else begin
          mc_d  = f_mc;
          wrc_d = f_wrc;
          a_d   = f_a;
          b_d   = f_b;
          alu_d = f_alu;
          case (f_nxt)
            NXT_INC:  upc_d = upc_inc;
            NXT_JMP:  upc_d = f_target;
            NXT_CJMP: upc_d = cond_true ? f_target : upc_inc;
            NXT_DISP: upc_d = bus.opcode;
            NXT_CALL: begin
              stk_d[push_ix] = upc_inc;
              sp_d           = sp_q + SP_W'(1);
              upc_d          = f_target;
            end
            NXT_RET: begin
              upc_d = stk_q[pop_ix];
              sp_d  = sp_q - SP_W'(1);
            end
            NXT_HALT:    upc_d = upc_q;
            NXT_RESTART: upc_d = '0;
            default:     upc_d = upc_inc;
          endcase
          if (is_mem) begin
            mem_req_d   = 1'b1;
            state_d     = S_MEMWAIT;
            halt_pend_d = (f_nxt == NXT_HALT);
          end else if (f_nxt == NXT_HALT) begin
            state_d = S_HALT;
          end
        end
      end

      S_MEMWAIT: begin
        if (bus.mem_ack) begin
          // Bubble with NOP fields so the memory word's WRC never writes twice
          mem_req_d = 1'b0;
          mc_d      = 2'b00;
          wrc_d     = NOP_WRC;
          a_d       = '0;
          b_d       = '0;
          alu_d     = '0;
          if (halt_pend_q) begin
            halt_pend_d = 1'b0;
            halted_d    = 1'b1;
            state_d     = S_HALT;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_HALT: begin
        halted_d  = 1'b1;
        mem_req_d = 1'b0;
        mc_d      = 2'b00;
        wrc_d     = NOP_WRC;
        a_d       = '0;
        b_d       = '0;
        alu_d     = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upc_q       <= '0;
      mc_q        <= 2'b00;
      wrc_q       <= NOP_WRC;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mem_req_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      sp_q        <= '0;
      stk_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      mc_q        <= mc_d;
      wrc_q       <= wrc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      mem_req_q   <= mem_req_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
      sp_q        <= sp_d;
      stk_q       <= stk_d;
    end
  end

  assign bus.uaddr     = upc_q;
  assign bus.MC        = mc_q;
  assign bus.WRC       = wrc_q;
  assign bus.busA      = a_q;
  assign bus.busB      = b_q;
  assign bus.alu_op    = alu_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: a ROM array feeds uinstr combinationally; a
// microinstruction-level reference model predicts uaddr and the registered
// control fields for every cycle. Memory handshake and reset are directed.
module tb_useq_ctrl;

  localparam int STK_D = 4;
  localparam int N_INC = 0, N_JMP = 1, N_CJMP = 2, N_DISP = 3;
  localparam int N_CALL = 4, N_RET = 5, N_HALT = 6, N_RST = 7;
  localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2;

  logic clk;
  logic rst_n;
  logic [35:0] rom [256];

  int checks;
  int failures;

  // reference model state
  int m_upc;
  int m_mode;
  int m_stk[$];
  bit m_err;

  useq_ctrl_if #(.UA_W(8)) ifc ();

  assign ifc.uinstr = rom[ifc.uaddr];

  useq_ctrl #(.UA_W(8), .STK_D(STK_D), .NOP_WRC(6'h3F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input int mc, input int wrc, input int a,
                                     input int b, input int alu, input int nxt,
                                     input int cond, input int addr);
    logic [35:0] w;
    w = {mc[1:0], wrc[5:0], a[4:0], b[5:0], alu[3:0], nxt[2:0], cond[1:0], addr[7:0]};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ifc.start   = 1'b0;
    ifc.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // start pulse from IDLE; model begins at address 0 with an empty stack
  task automatic start_run();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    m_upc  = 0;
    m_mode = M_RUN;
    m_err  = 1'b0;
    m_stk.delete();
    chk("start_uaddr", ifc.uaddr, 0);
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_mc"},  ifc.MC, 0);
    chk({tag, "_wrc"}, ifc.WRC, 6'h3F);
    chk({tag, "_a"},   ifc.busA, 0);
    chk({tag, "_b"},   ifc.busB, 0);
    chk({tag, "_alu"}, ifc.alu_op, 0);
  endtask

  // Predict one edge from the ROM word at the model's upc, then compare.
  task automatic model_tick(input string tag);
    logic [35:0] w;
    int nxt, cond, tgt, mc;
    bit ct, fault;
    int e_mc, e_wrc, e_a, e_b, e_alu;
    bit e_halted;
    e_mc = 0; e_wrc = 'h3F; e_a = 0; e_b = 0; e_alu = 0;
    e_halted = 1'b1;
    w = rom[m_upc];
    if (m_mode == M_RUN) begin
      mc   = int'(w[35:34]);
      nxt  = int'(w[12:10]);
      cond = int'(w[9:8]);
      tgt  = int'(w[7:0]);
      fault = (mc == 3) || (nxt == N_CALL && m_stk.size() == STK_D) ||
              (nxt == N_RET && m_stk.size() == 0);
      if (fault) begin
        m_err  = 1'b1;
        m_mode = M_HALTED;
      end else begin
        e_mc = mc; e_wrc = int'(w[33:28]); e_a = int'(w[27:23]);
        e_b = int'(w[22:17]); e_alu = int'(w[16:13]);
        e_halted = 1'b0;
        case (nxt)
          N_INC:  m_upc = (m_upc + 1) % 256;
          N_JMP:  m_upc = tgt;
          N_CJMP: begin
            ct = (cond == 0) ? ifc.flag_z : (cond == 1) ? ifc.flag_n :
                 (cond == 2) ? ifc.flag_c : 1'b1;
            m_upc = ct ? tgt : (m_upc + 1) % 256;
          end
          N_DISP: m_upc = int'(ifc.opcode);
          N_CALL: begin
            m_stk.push_back((m_upc + 1) % 256);
            m_upc = tgt;
          end
          N_RET:  m_upc = m_stk.pop_back();
          N_HALT: m_mode = M_HALTING;
          default: m_upc = 0;
        endcase
      end
    end else begin
      m_mode = M_HALTED;
    end
    tick();
    chk({tag, "_uaddr"},  ifc.uaddr, m_upc);
    chk({tag, "_mc"},     ifc.MC, e_mc);
    chk({tag, "_wrc"},    ifc.WRC, e_wrc);
    chk({tag, "_a"},      ifc.busA, e_a);
    chk({tag, "_b"},      ifc.busB, e_b);
    chk({tag, "_alu"},    ifc.alu_op, e_alu);
    chk({tag, "_halted"}, ifc.halted, e_halted);
    chk({tag, "_err"},    ifc.err, m_err);
    chk({tag, "_memreq"}, ifc.mem_req, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.mem_ack = 1'b0; ifc.opcode = '0;
    ifc.flag_z = 1'b0; ifc.flag_n = 1'b0; ifc.flag_c = 1'b0;
    rom_clear();

    // reset state
    do_reset();
    chk("rst_uaddr", ifc.uaddr, 0);
    chk_nop("rst");
    chk("rst_memreq", ifc.mem_req, 0);
    chk("rst_halted", ifc.halted, 0);
    chk("rst_err", ifc.err, 0);
    tick();
    chk("idle_uaddr", ifc.uaddr, 0);
    chk_nop("idle");

    // basic ALU word then HALT
    rom[0] = mk(0, 5, 1, 2, 3, N_INC, 0, 0);
    rom[1] = mk(0, 7, 4, 6, 9, N_HALT, 0, 0);
    start_run();
    for (int i = 0; i < 4; i++) model_tick("basic");
    chk("basic_wrc_nop", ifc.WRC, 6'h3F);

    // CJMP on Z taken / not taken, then COND=11
    for (int k = 0; k < 3; k++) begin
      do_reset(); rom_clear();
      rom[0] = mk(0, 1, 0, 0, 0, N_JMP, 0, 2);
      rom[2] = mk(0, 2, 0, 0, 0, N_CJMP, (k == 2) ? 3 : 0, 'h40);
      rom[3] = mk(0, 0, 0, 0, 0, N_HALT, 0, 0);
      rom['h40] = mk(0, 0, 0, 0, 0, N_HALT, 0, 0);
      ifc.flag_z = (k == 0); ifc.flag_n = 1'b0; ifc.flag_c = 1'b0;
      start_run();
      model_tick("cj_a");
      model_tick("cj_b");
      chk("cj_target", ifc.uaddr, (k == 1) ? 3 : 'h40);
      model_tick("cj_c");
      model_tick("cj_d");
    end

    // memory read with ack three cycles late
    do_reset(); rom_clear();
    rom[0] = mk(2, 9, 3, 4, 5, N_INC, 0, 0);
    rom[1] = mk(0, 4, 1, 1, 1, N_HALT, 0, 0);
    start_run();
    tick();
    chk("mr_mc", ifc.MC, 2);
    chk("mr_wrc", ifc.WRC, 9);
    chk("mr_req", ifc.mem_req, 1);
    chk("mr_uaddr", ifc.uaddr, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_hold_mc", ifc.MC, 2);
      chk("mr_hold_req", ifc.mem_req, 1);
      chk("mr_hold_uaddr", ifc.uaddr, 1);
    end
    ifc.mem_ack = 1'b1;
    tick();
    ifc.mem_ack = 1'b0;
    chk_nop("mr_bubble");
    chk("mr_bubble_req", ifc.mem_req, 0);
    tick();
    chk("mr_next_wrc", ifc.WRC, 4);
    chk("mr_next_mc", ifc.MC, 0);

    // memory write whose NXT is HALT: handshake first, then halt
    do_reset(); rom_clear();
    rom[0] = mk(1, 9, 0, 0, 0, N_HALT, 0, 0);
    start_run();
    tick();
    chk("mwh_mc", ifc.MC, 1);
    chk("mwh_req", ifc.mem_req, 1);
    chk("mwh_halted0", ifc.halted, 0);
    tick();
    chk("mwh_wait_req", ifc.mem_req, 1);
    ifc.mem_ack = 1'b1;
    tick();
    ifc.mem_ack = 1'b0;
    chk("mwh_halted", ifc.halted, 1);
    chk("mwh_req_off", ifc.mem_req, 0);
    chk_nop("mwh");
    chk("mwh_uaddr", ifc.uaddr, 0);

    // nested calls and returns, then overflow on the fifth call
    do_reset(); rom_clear();
    rom[0] = mk(0, 1, 0, 0, 0, N_CALL, 0, 'h10);
    rom['h10] = mk(0, 2, 0, 0, 0, N_CALL, 0, 'h20);
    rom['h20] = mk(0, 3, 0, 0, 0, N_CALL, 0, 'h30);
    rom['h30] = mk(0, 4, 0, 0, 0, N_CALL, 0, 'h40);
    rom['h40] = mk(0, 5, 0, 0, 0, N_RET, 0, 0);
    rom['h31] = mk(0, 6, 0, 0, 0, N_RET, 0, 0);
    rom['h21] = mk(0, 7, 0, 0, 0, N_RET, 0, 0);
    rom['h11] = mk(0, 8, 0, 0, 0, N_RET, 0, 0);
    rom[1] = mk(0, 9, 0, 0, 0, N_JMP, 0, 'h80);
    for (int i = 0; i < 5; i++) rom['h80 + i] = mk(0, 10 + i, 0, 0, 0, N_CALL, 0, 'h81 + i);
    start_run();
    for (int i = 0; i < 16; i++) model_tick("call");
    chk("call_err", ifc.err, 1);
    chk("call_halted", ifc.halted, 1);
    chk("call_uaddr", ifc.uaddr, 'h84);

    // RET on empty stack
    do_reset(); rom_clear();
    rom[0] = mk(0, 3, 0, 0, 0, N_RET, 0, 0);
    start_run();
    model_tick("ret_empty");
    chk("ret_empty_err", ifc.err, 1);
    model_tick("ret_empty_hold");

    // MC=11 fault
    do_reset(); rom_clear();
    rom[0] = mk(0, 3, 1, 1, 1, N_INC, 0, 0);
    rom[1] = mk(3, 3, 1, 1, 1, N_INC, 0, 0);
    start_run();
    model_tick("mc3_a");
    model_tick("mc3_b");
    chk("mc3_err", ifc.err, 1);
    chk("mc3_halted", ifc.halted, 1);

    // async reset mid-MEMWAIT, then restart from address 0
    do_reset(); rom_clear();
    rom[0] = mk(2, 9, 0, 0, 0, N_INC, 0, 0);
    start_run();
    tick();
    tick();
    chk("arst_pre_req", ifc.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", ifc.mem_req, 0);
    chk("arst_uaddr", ifc.uaddr, 0);
    chk("arst_state", ifc.dbg_state, 0);
    chk("arst_mc", ifc.MC, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    tick();
    chk("arst_resume_mc", ifc.MC, 2);
    chk("arst_resume_uaddr", ifc.uaddr, 1);

    // DISPATCH and upc wrap
    do_reset(); rom_clear();
    rom[0] = mk(0, 1, 0, 0, 0, N_DISP, 0, 0);
    rom['hA7] = mk(0, 2, 0, 0, 0, N_JMP, 0, 'hFF);
    rom['hFF] = mk(0, 3, 0, 0, 0, N_INC, 0, 0);
    rom[0] = mk(0, 1, 0, 0, 0, N_DISP, 0, 0);
    ifc.opcode = 8'hA7;
    start_run();
    model_tick("disp");
    chk("disp_uaddr", ifc.uaddr, 'hA7);
    model_tick("wrap_a");
    model_tick("wrap_b");
    chk("wrap_uaddr", ifc.uaddr, 0);

    // randomized programs against the model
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        int nxt;
        nxt = $urandom_range(0, 7);
        if (nxt == N_HALT && $urandom_range(0, 3) != 0) nxt = N_INC;
        rom[i] = mk(($urandom_range(0, 39) == 0) ? 3 : 0, $urandom_range(0, 63),
                    $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 15),
                    nxt, $urandom_range(0, 3), $urandom_range(0, 255));
      end
      start_run();
      for (int t = 0; t < 60; t++) begin
        ifc.flag_z  = 1'($urandom_range(0, 1));
        ifc.flag_n  = 1'($urandom_range(0, 1));
        ifc.flag_c  = 1'($urandom_range(0, 1));
        ifc.opcode  = 8'($urandom_range(0, 255));
        ifc.mem_ack = 1'($urandom_range(0, 1));
        ifc.start   = 1'($urandom_range(0, 1));
        model_tick("rand");
      end
      ifc.mem_ack = 1'b0;
      ifc.start   = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microprogram sequencer that drives the register bank's control fields (MC, WRC, busA, busB) plus the ALU op, one microinstruction per cycle.
- Reads an asynchronous microcode ROM through uaddr/uinstr.
- Supports branching on ALU flags, opcode dispatch and a small call/return stack.
- Stalls on a req/ack handshake for memory read/write microinstructions.

Parameters:
- UA_W, 8, microaddress width; also the width of opcode.
- STK_D, 4, call-stack depth (entries).
- NOP_WRC, 6'h3F, WRC value that addresses no register (no busC write).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin execution at uaddr 0.
- uaddr  out  UA_W  current microaddress (upc) to the ROM.
- uinstr  in  36  ROM word, combinational from uaddr. Fields, msb to lsb: MC[35:34], WRC[33:28], A[27:23], B[22:17], ALU[16:13], NXT[12:10], COND[9:8], ADDR[7:0].
- opcode  in  UA_W  instruction-register opcode used by DISPATCH.
- flag_z, flag_n, flag_c  in  1  ALU flags, sampled on the edge that executes the microinstruction.
- mem_req  out  1  memory operation pending.
- mem_ack  in  1  memory operation complete, single-cycle pulse.
- MC  out  2  bit0 = MW, bit1 = MR, to the register bank.
- WRC  out  6  busC write index.
- busA  out  5  operand A select.
- busB  out  6  operand B select.
- alu_op  out  4  ALU operation.
- halted  out  1  sequencer is in HALT.
- err  out  1  sticky fault flag, cleared only by reset.

Behaviour:
- States: IDLE, RUN, MEMWAIT, HALT.
- NOP output set: MC=00, WRC=NOP_WRC, busA=0, busB=0, alu_op=0.
- Reset (async, any state, including mid-MEMWAIT): state=IDLE, upc=0, stack empty, mem_req=0, halted=0, err=0, all control outputs = NOP.
- IDLE: outputs stay NOP. start=1 at an edge → RUN with upc=0. start is ignored in every other state.
- RUN, each edge:
  - MC, WRC, busA, busB, alu_op are registered from the uinstr fields. They appear one cycle after uaddr presents the word.
  - upc is updated per NXT in the same edge.
- NXT encoding:
  - 000 INC: upc+1.
  - 001 JMP: ADDR.
  - 010 CJMP: ADDR if the condition is true, else upc+1. COND 00=Z, 01=N, 10=C, 11=always.
  - 011 DISPATCH: opcode.
  - 100 CALL: push upc+1, then ADDR.
  - 101 RET: pop.
  - 110 HALT.
  - 111 RESTART: upc=0.
- upc arithmetic is modulo 2^UA_W; 0xFF+1 wraps to 0x00.
- Memory microinstruction (MC=01 or 10) in RUN:
  - Fields are registered, mem_req<=1, state→MEMWAIT, and upc advances per NXT as normal.
  - In MEMWAIT all outputs are held and mem_req stays 1.
  - mem_ack=1 at an edge: mem_req<=0, outputs ← NOP, state→RUN. That bubble cycle prevents a stale busC write.
  - The next microinstruction is registered on the following edge.
- HALT entry: registers the HALT word's fields for one cycle, then forces NOP outputs, halted=1, no further upc change. Exit only via reset.
- Faults (err<=1, enter HALT with NOP outputs, mem_req=0):
  - MC=11 in RUN.
  - CALL with the stack full (STK_D entries).
  - RET with the stack empty.
- mem_ack outside MEMWAIT is ignored.
- A memory microinstruction whose NXT is HALT completes the handshake first, then halts.

Test Plan:
- Reset, start, ROM[0]={MC=00,WRC=5,A=1,B=2,ALU=3,INC}, ROM[1]=HALT → cycle after start: uaddr=0. Next cycle: WRC=5, busA=1, busB=2, alu_op=3. Then halted=1 with outputs NOP, err=0.
- ROM[2]=CJMP Z to 0x40. With flag_z=1 → upc=0x40. With flag_z=0 → upc=3. Repeat with COND=11 → 0x40 regardless of flags.
- Memory read ROM[0]={MC=10,INC}, mem_ack delayed 3 cycles → MC=10 and mem_req=1 held 4 cycles. Ack edge → MC=00, WRC=0x3F for one cycle, then ROM[1] fields appear.
- Nested CALLs: four CALLs then four RETs → return addresses popped in LIFO order. A fifth CALL → err=1, halted=1.
- RET on empty stack, and a microinstruction with MC=11 → err=1, halted=1, mem_req=0, outputs NOP.
- rst_n low for 1 cycle mid-MEMWAIT → mem_req=0 immediately (async), state IDLE, uaddr=0, a later start resumes from address 0. DISPATCH with opcode=0xA7 → uaddr=0xA7. upc at 0xFF with INC → 0x00.
